// File: rtl/grooving_tx_pkg.sv
// rtl/grooving_tx_pkg.sv - shared constants and per-sample scale/saturate for the TX splitter
// Purpose: sample geometry, lane index constants and the Q1.7 scale-round-saturate helper.
// Ports: none (package).
package grooving_tx_pkg;

  localparam int SSAMPLE_W = 8;
  localparam int MSAMPLE_W = 8;
  localparam int WEIGHT_W  = 8;
  localparam int SAMPLES   = 16;

  localparam int L00 = 0;
  localparam int L01 = 1;
  localparam int L20 = 2;
  localparam int L21 = 3;

  // Product width is wide enough for the full s*w range plus the rounding bias.
  localparam int PW = SSAMPLE_W + WEIGHT_W;

  localparam logic signed [PW-1:0] RND   = PW'(2 ** (WEIGHT_W - 2));
  localparam logic signed [PW-1:0] Y_MAX = PW'(2 ** (MSAMPLE_W - 1) - 1);
  localparam logic signed [PW-1:0] Y_MIN = PW'(-(2 ** (MSAMPLE_W - 1)));

  // Returns {sat, y}: y = round-half-up(s*w / 2^(WW-1)) clipped to the output range.
  function automatic logic [MSAMPLE_W:0] scale_sat(
    input logic signed [SSAMPLE_W-1:0] s,
    input logic signed [WEIGHT_W-1:0]  w
  );
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] y;
    p = PW'(s) * PW'(w) + RND;
    y = p >>> (WEIGHT_W - 1);
    if (y > Y_MAX) begin
      return {1'b1, Y_MAX[MSAMPLE_W-1:0]};
    end else if (y < Y_MIN) begin
      return {1'b1, Y_MIN[MSAMPLE_W-1:0]};
    end else begin
      return {1'b0, y[MSAMPLE_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/axi_tx_lane.sv
// rtl/axi_tx_lane.sv - one DAC lane: scale/saturate all samples and hold them in an output slot
// Purpose: scales a full input beat by this lane's weight and registers it with valid/last.
// Ports:
//   clock, resetn      clock and synchronous active-low reset
//   load               capture this beat into the slot on the next posedge
//   wdata, wlast       input beat and its last flag
//   weight             signed Q1.(WW-1) lane weight
//   rready             downstream ready
//   rdata,rvalid,rlast output slot
//   slot_free          slot can take a beat this cycle (~rvalid | rready)
//   clip               some sample of the current input beat saturates
module axi_tx_lane import grooving_tx_pkg::*; #(
  parameter int SSW = SSAMPLE_W,
  parameter int MSW = MSAMPLE_W,
  parameter int WW  = WEIGHT_W,
  parameter int NS  = SAMPLES
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [NS*SSW-1:0]    wdata,
  input  logic                 wlast,
  input  logic signed [WW-1:0] weight,
  input  logic                 rready,
  output logic [NS*MSW-1:0]    rdata,
  output logic                 rvalid,
  output logic                 rlast,
  output logic                 slot_free,
  output logic                 clip
);

  logic [NS*MSW-1:0] y;
  logic [NS-1:0]     sat;

  for (genvar i = 0; i < NS; i++) begin : g_smp
    assign {sat[i], y[i*MSW +: MSW]} = scale_sat(wdata[i*SSW +: SSW], weight);
  end

  assign clip      = |sat;
  assign slot_free = ~rvalid | rready;

  // A load takes priority over a drain so a same-cycle drain+accept keeps rvalid high.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end else if (load) begin
      rdata  <= y;
      rlast  <= wlast;
      rvalid <= 1'b1;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_tx_splitter.sv
// rtl/axi_tx_splitter.sv - fans one sample stream out to four weighted DAC lane streams
// Purpose: input handshake, lane enable gating, beat/frame counters and sticky saturation flags.
// Ports:
//   clock, resetn                   clock and synchronous active-low reset
//   bWeightXX_real                  per-lane signed Q1.7 weight (XX = 00,01,20,21)
//   chan_en                         lane enables [0]=00 [1]=01 [2]=20 [3]=21
//   clr_stat                        clears counters and sat_flag
//   s00_axi_w*                      input stream (wdata/wvalid/wlast/wready)
//   mXX_axi_r*                      per-lane output streams (rdata/rvalid/rlast/rready)
//   beat_count, frame_count         accepted beats / accepted last beats, wrapping
//   sat_flag                        sticky per-lane saturation
module axi_tx_splitter import grooving_tx_pkg::*; #(
  parameter int SDATA_WIDTH   = 128,
  parameter int MDATA_WIDTH   = 128,
  parameter int SSAMPLE_WIDTH = SSAMPLE_W,
  parameter int MSAMPLE_WIDTH = MSAMPLE_W,
  parameter int WEIGHT_WIDTH  = WEIGHT_W,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WEIGHT_WIDTH-1:0] bWeight00_real,
  input  logic [WEIGHT_WIDTH-1:0] bWeight01_real,
  input  logic [WEIGHT_WIDTH-1:0] bWeight20_real,
  input  logic [WEIGHT_WIDTH-1:0] bWeight21_real,
  input  logic [3:0]              chan_en,
  input  logic                    clr_stat,
  input  logic [SDATA_WIDTH-1:0]  s00_axi_wdata,
  input  logic                    s00_axi_wvalid,
  input  logic                    s00_axi_wlast,
  output logic                    s00_axi_wready,
  output logic [MDATA_WIDTH-1:0]  m00_axi_rdata,
  output logic                    m00_axi_rvalid,
  output logic                    m00_axi_rlast,
  input  logic                    m00_axi_rready,
  output logic [MDATA_WIDTH-1:0]  m01_axi_rdata,
  output logic                    m01_axi_rvalid,
  output logic                    m01_axi_rlast,
  input  logic                    m01_axi_rready,
  output logic [MDATA_WIDTH-1:0]  m20_axi_rdata,
  output logic                    m20_axi_rvalid,
  output logic                    m20_axi_rlast,
  input  logic                    m20_axi_rready,
  output logic [MDATA_WIDTH-1:0]  m21_axi_rdata,
  output logic                    m21_axi_rvalid,
  output logic                    m21_axi_rlast,
  input  logic                    m21_axi_rready,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [3:0]              sat_flag
);

  localparam int NS = SDATA_WIDTH / SSAMPLE_WIDTH;

  logic [WEIGHT_WIDTH-1:0] weight [4];
  logic [MDATA_WIDTH-1:0]  rdata_a [4];
  logic [3:0] rready_v, rvalid_v, rlast_v, free_v, clip_v, load_v;
  logic       accept;

  assign weight[L00] = bWeight00_real;
  assign weight[L01] = bWeight01_real;
  assign weight[L20] = bWeight20_real;
  assign weight[L21] = bWeight21_real;

  assign rready_v = {m21_axi_rready, m20_axi_rready, m01_axi_rready, m00_axi_rready};

  // Disabled lanes never gate the input, so a stalled beat parked in a disabled lane
  // cannot block the remaining lanes.
  assign s00_axi_wready = resetn & (&(~chan_en | free_v));
  assign accept         = s00_axi_wvalid & s00_axi_wready;
  assign load_v         = {4{accept}} & chan_en;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    axi_tx_lane #(
      .SSW (SSAMPLE_WIDTH),
      .MSW (MSAMPLE_WIDTH),
      .WW  (WEIGHT_WIDTH),
      .NS  (NS)
    ) u_lane (
      .clock     (clock),
      .resetn    (resetn),
      .load      (load_v[i]),
      .wdata     (s00_axi_wdata),
      .wlast     (s00_axi_wlast),
      .weight    (weight[i]),
      .rready    (rready_v[i]),
      .rdata     (rdata_a[i]),
      .rvalid    (rvalid_v[i]),
      .rlast     (rlast_v[i]),
      .slot_free (free_v[i]),
      .clip      (clip_v[i])
    );
  end

  assign m00_axi_rdata  = rdata_a[L00];
  assign m01_axi_rdata  = rdata_a[L01];
  assign m20_axi_rdata  = rdata_a[L20];
  assign m21_axi_rdata  = rdata_a[L21];
  assign m00_axi_rvalid = rvalid_v[L00];
  assign m01_axi_rvalid = rvalid_v[L01];
  assign m20_axi_rvalid = rvalid_v[L20];
  assign m21_axi_rvalid = rvalid_v[L21];
  assign m00_axi_rlast  = rlast_v[L00];
  assign m01_axi_rlast  = rlast_v[L01];
  assign m20_axi_rlast  = rlast_v[L20];
  assign m21_axi_rlast  = rlast_v[L21];

  // clr_stat outranks any same-cycle increment or saturation set.
  always_ff @(posedge clock) begin
    if (!resetn || clr_stat) begin
      beat_count  <= '0;
      frame_count <= '0;
      sat_flag    <= '0;
    end else begin
      if (accept) begin
        beat_count <= beat_count + CNT_WIDTH'(1);
        if (s00_axi_wlast) begin
          frame_count <= frame_count + CNT_WIDTH'(1);
        end
      end
      sat_flag <= sat_flag | (clip_v & load_v);
    end
  end

endmodule
